// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages.
// Optional MEM_ARB_ALIGN_CHECK_EN: flag misaligned DM word accesses.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_byte,
  input  logic        dm_signextend,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_err,
  output logic        mem_en,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t      state, state_nx;
  logic        own_dm, byte_q, sext_q;
  logic [3:0]  starve_cnt, be_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] if_rdata_q, dm_rdata_q, ld_data;
  logic [7:0]  ld_byte;
  logic        any_req, if_win, mis, acked, grant;

  assign any_req = if_req | dm_req;
  assign if_win  = if_req & (~dm_req | (starve_cnt == LIM));
  assign grant   = (state == IDLE) & any_req;
  assign acked   = mem_ack & ((state == ISSUE) | (state == WAIT));

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic err_q;
  assign mis    = dm_req & ~if_win & ~dm_byte
                & (dm_addr[1:0] != 2'b00);
  assign dm_err = dm_valid & err_q;

  // remember whether the granted DM access was rejected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     err_q <= 1'b0;
    else if (grant) err_q <= mis;
  end
`else
  assign mis    = 1'b0;
  assign dm_err = 1'b0;
`endif

  assign mem_en    = (state == ISSUE);
  assign mem_be    = be_q;
  assign mem_addr  = addr_q[31:2];
  assign mem_wdata = wdata_q;
  assign if_valid  = (state == RESP) & ~own_dm;
  assign dm_valid  = (state == RESP) & own_dm;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = mis ? RESP : ISSUE;
      ISSUE:   state_nx = mem_ack ? RESP : WAIT;
      WAIT:    if (mem_ack) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // load lane select and extension
  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_data = byte_q
            ? {{24{sext_q & ld_byte[7]}}, ld_byte}
            : mem_rdata;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // latch owner, address and lane-formatted controls at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_dm  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
    end else if (grant) begin
      own_dm <= ~if_win;
      if (if_win) begin
        addr_q  <= if_addr;
        be_q    <= '0;
        wdata_q <= '0;
        byte_q  <= 1'b0;
        sext_q  <= 1'b0;
      end else begin
        addr_q <= dm_addr;
        byte_q <= dm_byte;
        sext_q <= dm_signextend;
        if (!dm_we) begin
          be_q    <= '0;
          wdata_q <= '0;
        end else if (dm_byte) begin
          be_q    <= 4'b0001 << dm_addr[1:0];
          wdata_q <= {4{dm_wdata[7:0]}};
        end else begin
          be_q    <= 4'hF;
          wdata_q <= dm_wdata;
        end
      end
    end
  end

  // fetch starvation counter, updated only at arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!if_req || if_win)
        starve_cnt <= '0;
      else if (!mis && starve_cnt != LIM)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // capture read data for the owner on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (grant && mis) begin
      dm_rdata_q <= '0;
    end else if (acked) begin
      if (own_dm) dm_rdata_q <= ld_data;
      else        if_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state memory model.
// Build with MEM_ARB_ALIGN_CHECK_EN to exercise the alignment path.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_byte, dm_signextend;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_valid, dm_err;
  logic        mem_en, mem_ack;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_tot = 0;
  int n_bad = 0;

  int wcfg = 0;
  int wcnt;
  logic ack_force = 0;

  int cyc = 0;
  int n_ifv = 0;
  int n_dmv = 0;
  int ifv_c = 0;
  int dmv_c = 0;
  logic [29:0] en_q[$];
  int          en_c[$];

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_byte(dm_byte), .dm_signextend(dm_signextend),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_err(dm_err),
    .mem_en(mem_en), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // memory: ack after wcfg wait cycles
  assign mem_ack = ack_force
                 || (mem_en && wcfg == 0)
                 || (wcnt != 0 && wcnt == wcfg);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wcnt <= 0;
    else if (mem_ack)              wcnt <= 0;
    else if (mem_en || wcnt != 0)  wcnt <= wcnt + 1;
  end

  // record grants and valid pulses per cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_en) begin
      en_q.push_back(mem_addr);
      en_c.push_back(cyc);
    end
    if (if_valid) begin n_ifv++; ifv_c = cyc; end
    if (dm_valid) begin n_dmv++; dmv_c = cyc; end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_op(input logic we, input logic byt,
                       input logic sx,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] rd,
                       output logic [3:0] be,
                       output logic [31:0] mwd,
                       output logic [29:0] ma,
                       output logic [31:0] res,
                       output logic err,
                       output int ne, output int lat);
    be = '0; mwd = '0; ma = '0; res = '0;
    err = 0; ne = 0; lat = -1;
    mem_rdata = rd; dm_we = we; dm_byte = byt;
    dm_signextend = sx; dm_addr = a; dm_wdata = wd;
    dm_req = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_en) begin
        ne++; be = mem_be; mwd = mem_wdata; ma = mem_addr;
      end
      if (dm_valid) begin
        res = dm_rdata; err = dm_err; lat = k;
        dm_req = 0;
        break;
      end
    end
    chk("dm_done", 32'(dm_req), 32'h0);
    dm_req = 0;
    tick();
    tick();
  endtask

  logic [3:0]  be;
  logic [31:0] mwd, res, got_if;
  logic [29:0] ma;
  logic        err;
  int          ne, lat, s0, v_if, v_dm;
  logic [29:0] stv_exp[6];

  initial begin
    rst_n = 0; if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_byte = 0;
    dm_signextend = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    #12;
    chk("rst_ctl", 32'({mem_en, mem_be, if_valid,
                        dm_valid, dm_err}), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    tick();

    // single LW at 0x100, zero wait, then back-to-back LW
    wcfg = 0; mem_rdata = 32'hDEADBEEF;
    dm_we = 0; dm_byte = 0; dm_addr = 32'h100;
    dm_req = 1;
    tick();
    chk("lw_en", 32'(mem_en), 32'h1);
    chk("lw_addr", 32'(mem_addr), 32'h40);
    chk("lw_be", 32'(mem_be), 32'h0);
    chk("lw_novalid", 32'(dm_valid), 32'h0);
    tick();
    chk("lw_en_off", 32'(mem_en), 32'h0);
    chk("lw_valid", 32'(dm_valid), 32'h1);
    chk("lw_rdata", dm_rdata, 32'hDEADBEEF);
    dm_addr = 32'h200; mem_rdata = 32'h12345678;
    tick();
    chk("lw_gap", 32'({mem_en, dm_valid}), 32'h0);
    tick();
    chk("lw2_en", 32'(mem_en), 32'h1);
    chk("lw2_addr", 32'(mem_addr), 32'h80);
    tick();
    chk("lw2_rdata", dm_rdata, 32'h12345678);
    dm_req = 0;
    tick(); tick();

    // both requests together, two wait cycles
    wcfg = 2; mem_rdata = 32'hCAFEF00D;
    s0 = en_q.size(); v_if = n_ifv; v_dm = n_dmv;
    got_if = '0;
    if_addr = 32'h800; dm_addr = 32'h400; dm_we = 0;
    if_req = 1; dm_req = 1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (dm_valid) dm_req = 0;
      if (if_valid) begin got_if = if_rdata; if_req = 0; end
      if (!dm_req && !if_req) break;
    end
    chk("both_done", 32'({if_req, dm_req}), 32'h0);
    if_req = 0; dm_req = 0;
    tick(); tick();
    chk("both_grants", 32'(en_q.size() - s0), 32'd2);
    chk("both_first_dm", 32'(en_q[s0]), 32'h100);
    chk("both_then_if", 32'(en_q[s0+1]), 32'h200);
    chk("both_dm_lat", 32'(dmv_c - en_c[s0]), 32'd3);
    chk("both_if_lat", 32'(ifv_c - en_c[s0+1]), 32'd3);
    chk("both_period", 32'(en_c[s0+1] - en_c[s0]), 32'd5);
    chk("both_dm_once", 32'(n_dmv - v_dm), 32'd1);
    chk("both_if_once", 32'(n_ifv - v_if), 32'd1);
    chk("both_if_rdata", got_if, 32'hCAFEF00D);

    // byte lanes, stores and loads
    wcfg = 1;
    dm_op(1, 1, 0, 32'h1003, 32'h000000AB, 32'h0,
          be, mwd, ma, res, err, ne, lat);
    chk("sb3_be", 32'(be), 32'h8);
    chk("sb3_wd", mwd, 32'hABABABAB);
    chk("sb3_addr", 32'(ma), 32'h400);
    dm_op(1, 1, 0, 32'h1000, 32'hFFFFFF5C, 32'h0,
          be, mwd, ma, res, err, ne, lat);
    chk("sb0_be", 32'(be), 32'h1);
    chk("sb0_wd", mwd, 32'h5C5C5C5C);
    dm_op(1, 0, 0, 32'h2000, 32'h11223344, 32'h0,
          be, mwd, ma, res, err, ne, lat);
    chk("sw_be", 32'(be), 32'hF);
    chk("sw_wd", mwd, 32'h11223344);
    dm_op(0, 1, 1, 32'h1002, 32'h0, 32'h00800000,
          be, mwd, ma, res, err, ne, lat);
    chk("lb_be", 32'(be), 32'h0);
    chk("lb_neg", res, 32'hFFFFFF80);
    dm_op(0, 1, 0, 32'h1002, 32'h0, 32'h00800000,
          be, mwd, ma, res, err, ne, lat);
    chk("lbu", res, 32'h00000080);
    dm_op(0, 1, 1, 32'h1001, 32'h0, 32'hFFFF7FFF,
          be, mwd, ma, res, err, ne, lat);
    chk("lb_pos", res, 32'h0000007F);
    dm_op(0, 0, 0, 32'h2000, 32'h0, 32'h89ABCDEF,
          be, mwd, ma, res, err, ne, lat);
    chk("lw_word", res, 32'h89ABCDEF);
    chk("lw_err", 32'(err), 32'h0);

    // misaligned word load
    wcfg = 0;
    dm_op(0, 0, 0, 32'h102, 32'h0, 32'h77777777,
          be, mwd, ma, res, err, ne, lat);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk("mis_no_mem", 32'(ne), 32'd0);
    chk("mis_lat", 32'(lat), 32'd0);
    chk("mis_err", 32'(err), 32'h1);
    chk("mis_rdata", res, 32'h0);
`else
    chk("mis_mem", 32'(ne), 32'd1);
    chk("mis_addr", 32'(ma), 32'h40);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(err), 32'h0);
    chk("mis_rdata", res, 32'h77777777);
`endif

    // starvation: DM held, IF pending
    wcfg = 0; mem_rdata = 32'h0BADF00D;
    s0 = en_q.size();
    if_addr = 32'h800; dm_addr = 32'h400;
    dm_we = 0; dm_byte = 0;
    if_req = 1; dm_req = 1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (if_valid) if_req = 0;
      if (dm_valid && en_q.size() - s0 >= 6) begin
        dm_req = 0;
        break;
      end
    end
    chk("stv_done", 32'({if_req, dm_req}), 32'h0);
    if_req = 0; dm_req = 0;
    tick(); tick();
    stv_exp = '{30'h100, 30'h100, 30'h100,
                30'h100, 30'h200, 30'h100};
    for (int i = 0; i < 6; i++)
      chk("stv_order", 32'(en_q[s0+i]), 32'(stv_exp[i]));

    // reset while waiting on memory
    wcfg = 3; dm_addr = 32'h300; dm_req = 1;
    tick();
    tick();
    chk("wait_en", 32'({mem_en, dm_valid}), 32'h0);
    chk("wait_addr", 32'(mem_addr), 32'hC0);
    #2;
    rst_n = 0; dm_req = 0;
    #1;
    chk("mid_rst_ctl", 32'({mem_en, mem_be, if_valid,
                            dm_valid, dm_err}), 32'h0);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_rdata", if_rdata | dm_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    v_dm = n_dmv; s0 = en_q.size();
    ack_force = 1;
    tick(); tick();
    ack_force = 0;
    tick();
    chk("stray_ack_valid", 32'(n_dmv - v_dm), 32'h0);
    chk("stray_ack_en", 32'(en_q.size() - s0), 32'h0);
    wcfg = 1;
    dm_op(0, 0, 0, 32'h300, 32'h0, 32'h55AA55AA,
          be, mwd, ma, res, err, ne, lat);
    chk("post_rst_addr", 32'(ma), 32'hC0);
    chk("post_rst_rdata", res, 32'h55AA55AA);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
